replica_capture_monitor: RTL and testbench
==========================================

# replica_capture_monitor

Launch-and-capture controller for the replica ALU delay chain. Every cycle it toggles a launch flop driving the chain input, then samples the chain output at the next rising edge. A mismatch against the expected value means the replica path did not settle inside one clock period, so the core is near its timing limit. Mismatches are counted over fixed windows, and a request/acknowledge alarm is raised to the pipeline/DVFS controller when a window exceeds threshold.

## Interface
Parameters:
- CHAIN_INV, 28, number of inverters in the replica chain; bit 0 gives output parity
- WINDOW, 256, checked cycles per evaluation window (power of two, ≥ 4)
- ERR_THRESH, 4, mismatches per window that trigger an alarm (1..WINDOW)
- CNT_W, 9, width of the error counters (must hold WINDOW)

Ports (clock `clk_i`; reset `rst_ni` is asynchronous and active-low):
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  monitoring enable, level
- launch_o  out  1  drives replica chain input A, straight from a flop
- replica_i  in  1  replica chain output Y, sampled raw with no synchroniser
- err_pulse_o  out  1  one-cycle pulse per detected mismatch
- err_count_o  out  CNT_W  mismatch count of last completed window
- window_done_o  out  1  one-cycle pulse when a window closes
- alarm_req_o  out  1  alarm request, held until acknowledged
- alarm_ack_i  in  1  alarm acknowledge from controller
- alarm_ovr_o  out  1  sticky: a window exceeded threshold while alarm_req_o was pending

## Operation
- Expected capture value: exp = launch_q XOR CHAIN_INV[0].
- States:
  - IDLE: launch_q holds. enable_i=1 moves to PRIME.
  - PRIME: launch_q toggles. No check this cycle. Moves to RUN.
  - RUN: launch_q toggles every cycle. At each edge, mismatch = replica_i != exp, evaluated on the launch_q value from before this edge.
  - enable_i=0 in PRIME or RUN moves to IDLE on the next edge, with no check on that edge.
- Window counter (wcnt) increments per checked cycle. Error counter (ecnt) increments per mismatch and saturates at 2^CNT_W−1.
- Window close (wcnt = WINDOW−1 on a checked edge):
  - err_count_o ← ecnt including the current mismatch.
  - window_done_o pulses.
  - wcnt and ecnt clear.
  - If total ≥ ERR_THRESH: set alarm_req_o if it is clear, otherwise set alarm_ovr_o.
- Alarm handshake:
  - alarm_req_o clears on the edge after alarm_ack_i=1 is seen while alarm_req_o=1.
  - alarm_ack_i while alarm_req_o=0 is ignored.
  - Ack and a new threshold hit on the same edge: alarm_req_o stays 1 and alarm_ovr_o is not set.
- alarm_ovr_o is cleared only by reset.
- Leaving RUN clears wcnt and ecnt (partial window discarded). alarm_req_o, alarm_ovr_o and err_count_o are retained.

## Timing
- Reset values: launch_o=0, err_pulse_o=0, err_count_o=0, window_done_o=0, alarm_req_o=0, alarm_ovr_o=0, state IDLE, counters 0.
- Reset mid-operation takes effect immediately (asynchronous). No alarm is emitted for the partial window.
- launch_o toggles on edge k. The corresponding sample is taken on edge k+1. err_pulse_o is high in the cycle after edge k+1 (1-cycle latency).
- First check happens on the second edge after enable_i rises (PRIME absorbs the first launch).
- window_done_o and alarm_req_o assert on the same edge, WINDOW checked edges after entering RUN.
- Timing constraints: replica_i is not a false path; the launch_q → chain → capture path is intentionally critical.

## Configuration
- Macro: REPLICA_MON_STUCK_EN.
- Defined:
  - Adds output `stuck_o` (1 bit, reset 0) and a 4-bit run counter.
  - If replica_i is unchanged on 8 consecutive checked edges in RUN, stuck_o sets sticky (cleared by reset).
  - Stuck cycles still count as mismatches.
- Undefined: no stuck_o port and no run counter. Behaviour is otherwise identical.

## Structure
- Package `replica_mon_pkg`:
  - state enum (IDLE, PRIME, RUN)
  - function `exp_parity(CHAIN_INV)`
  - default parameter constants
- Sub-module `replica_mon_window`: wcnt/ecnt, saturation, window close and threshold compare, with inputs check_i, err_i and clear_i.
- The top level holds the FSM, launch/capture flops and alarm handshake.
- The replica chain itself is instantiated outside this block.

## Test plan
- Ideal chain (testbench drives replica_i = launch_o each cycle), WINDOW=256: err_pulse_o never asserts; err_count_o=0 at each window_done_o; alarm_req_o stays 0.
- Testbench delays replica_i by one cycle (chain too slow): every check mismatches; err_count_o=256 after the first window; alarm_req_o=1 on the same edge as window_done_o.
- Exactly 3 then 4 mismatches injected, ERR_THRESH=4: first window gives no alarm with err_count_o=3; second window asserts alarm_req_o with err_count_o=4.
- Hold alarm_ack_i=0 across two failing windows: alarm_ovr_o=1 after the second. Ack then clears alarm_req_o one edge later; alarm_ovr_o stays 1.
- Drop enable_i after 100 checked cycles with 10 errors, then re-enable: counters restart; next err_count_o counts only post-re-enable errors; launch_o held while IDLE.
- Assert rst_ni low mid-window with alarm_req_o=1: all outputs 0 immediately. With REPLICA_MON_STUCK_EN, replica_i held at 0 for 8 checked edges → stuck_o=1.

Source files
------------

// File: rtl/replica_mon_pkg.sv
// rtl/replica_mon_pkg.sv - shared types, defaults and helpers for the replica capture monitor
package replica_mon_pkg;

  localparam int DEF_CHAIN_INV  = 28;
  localparam int DEF_WINDOW     = 256;
  localparam int DEF_ERR_THRESH = 4;
  localparam int DEF_CNT_W      = 9;
  localparam int STUCK_RUN      = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } state_t;

  // An odd inverter count inverts the launched value at the chain output.
  function automatic logic exp_parity(input int unsigned chain_inv);
    return chain_inv[0];
  endfunction

endpackage

// File: rtl/replica_capture_monitor_if.sv
// rtl/replica_capture_monitor_if.sv - monitor control/status bundle; stuck_o exists under REPLICA_MON_STUCK_EN
interface replica_capture_monitor_if #(
  parameter int CNT_W = 9
) ();

  logic             enable_i;
  logic             launch_o;
  logic             replica_i;
  logic             err_pulse_o;
  logic [CNT_W-1:0] err_count_o;
  logic             window_done_o;
  logic             alarm_req_o;
  logic             alarm_ack_i;
  logic             alarm_ovr_o;
`ifdef REPLICA_MON_STUCK_EN
  logic             stuck_o;
`endif

  modport master (
    input  enable_i, replica_i, alarm_ack_i,
    output launch_o, err_pulse_o, err_count_o, window_done_o, alarm_req_o, alarm_ovr_o
`ifdef REPLICA_MON_STUCK_EN
    , output stuck_o
`endif
  );

  modport slave (
    output enable_i, replica_i, alarm_ack_i,
    input  launch_o, err_pulse_o, err_count_o, window_done_o, alarm_req_o, alarm_ovr_o
`ifdef REPLICA_MON_STUCK_EN
    , input stuck_o
`endif
  );

endinterface

// File: rtl/replica_mon_window.sv
// rtl/replica_mon_window.sv - checked-cycle window, saturating error count and threshold compare
module replica_mon_window
  import replica_mon_pkg::*;
#(
  parameter int WINDOW     = DEF_WINDOW,
  parameter int ERR_THRESH = DEF_ERR_THRESH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             check_i,
  input  logic             err_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o,
  output logic             hit_o
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(ERR_THRESH);
  localparam logic [CNT_W-1:0] SAT    = '1;

  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_ecnt;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  logic [CNT_W-1:0] w_total;
  logic             w_close;

  // Total includes the mismatch of the current edge so the closing check is not lost.
  assign w_total = (check_i && err_i && (r_ecnt != SAT)) ? r_ecnt + 1'b1 : r_ecnt;
  assign w_close = check_i && (r_wcnt == LAST);
  assign hit_o   = w_close && (w_total >= THRESH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wcnt  <= '0;
      r_ecnt  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (clear_i) begin
      r_wcnt <= '0;
      r_ecnt <= '0;
      r_done <= 1'b0;
    end else if (w_close) begin
      r_wcnt  <= '0;
      r_ecnt  <= '0;
      r_count <= w_total;
      r_done  <= 1'b1;
    end else begin
      r_wcnt <= r_wcnt + 1'b1;
      r_ecnt <= w_total;
      r_done <= 1'b0;
    end
  end

  assign count_o = r_count;
  assign done_o  = r_done;

endmodule

// File: rtl/replica_capture_monitor.sv
// rtl/replica_capture_monitor.sv - replica chain launch/capture FSM, alarm handshake; REPLICA_MON_STUCK_EN adds stuck_o
module replica_capture_monitor
  import replica_mon_pkg::*;
#(
  parameter int CHAIN_INV  = DEF_CHAIN_INV,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int ERR_THRESH = DEF_ERR_THRESH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  replica_capture_monitor_if.master bus
);

  localparam logic EXP_INV = exp_parity(CHAIN_INV);

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_launch;
  logic             w_launch_nx;
  logic             w_check;
  logic             w_mismatch;
  logic             r_err_pulse;
  logic             r_alarm_req;
  logic             r_alarm_ovr;
  logic             w_win_done;
  logic             w_hit;
  logic [CNT_W-1:0] w_err_count;

  always_comb begin
    w_state_nx  = r_state;
    w_launch_nx = r_launch;
    w_check     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.enable_i) w_state_nx = ST_PRIME;
      end
      ST_PRIME: begin
        if (bus.enable_i) begin
          w_state_nx  = ST_RUN;
          w_launch_nx = ~r_launch;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.enable_i) begin
          w_launch_nx = ~r_launch;
          w_check     = 1'b1;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Compared against the launch value from before this edge: one period of settle time.
  assign w_mismatch = bus.replica_i != (r_launch ^ EXP_INV);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_launch    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_launch    <= w_launch_nx;
      r_err_pulse <= w_check && w_mismatch;
    end
  end

  replica_mon_window #(
    .WINDOW    (WINDOW),
    .ERR_THRESH(ERR_THRESH),
    .CNT_W     (CNT_W)
  ) u_window (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .check_i(w_check),
    .err_i  (w_mismatch),
    .clear_i(!w_check),
    .count_o(w_err_count),
    .done_o (w_win_done),
    .hit_o  (w_hit)
  );

  // A fresh hit arriving with the ack re-arms the request instead of flagging overrun.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alarm_req <= 1'b0;
      r_alarm_ovr <= 1'b0;
    end else if (r_alarm_req && bus.alarm_ack_i) begin
      r_alarm_req <= w_hit;
    end else if (w_hit) begin
      if (r_alarm_req) r_alarm_ovr <= 1'b1;
      else             r_alarm_req <= 1'b1;
    end
  end

`ifdef REPLICA_MON_STUCK_EN
  logic [3:0] r_run;
  logic       r_prev_rep;
  logic       r_stuck;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run      <= '0;
      r_prev_rep <= 1'b0;
      r_stuck    <= 1'b0;
    end else if (!w_check) begin
      r_run <= '0;
    end else begin
      r_prev_rep <= bus.replica_i;
      if ((r_run != 4'd0) && (bus.replica_i == r_prev_rep)) begin
        if (r_run != 4'hf) r_run <= r_run + 4'd1;
        if (r_run >= 4'(STUCK_RUN - 1)) r_stuck <= 1'b1;
      end else begin
        r_run <= 4'd1;
      end
    end
  end

  assign bus.stuck_o = r_stuck;
`endif

  assign bus.launch_o      = r_launch;
  assign bus.err_pulse_o   = r_err_pulse;
  assign bus.err_count_o   = w_err_count;
  assign bus.window_done_o = w_win_done;
  assign bus.alarm_req_o   = r_alarm_req;
  assign bus.alarm_ovr_o   = r_alarm_ovr;

endmodule

// File: tb/tb_replica_capture_monitor.sv
// tb/tb_replica_capture_monitor.sv - directed-vector bench for replica_capture_monitor
module tb_replica_capture_monitor;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode  = 2'd0;
  logic       inj   = 1'b0;
  logic       r_dly = 1'b0;
  int         n_vec = 0;
  int         n_miss = 0;
  int         n_pulse = 0;
  int         last_wait = 0;
  int         p0;
  logic       l0;

  replica_capture_monitor_if #(.CNT_W(9)) u_if ();

  replica_capture_monitor #(
    .CHAIN_INV (28),
    .WINDOW    (256),
    .ERR_THRESH(4),
    .CNT_W     (9)
  ) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (u_if.master)
  );

  always #5 clk = ~clk;

  // mode 0: ideal chain, 1: one cycle too slow, 2: ideal with injected flips, 3: stuck at 0
  always @(posedge clk) r_dly <= u_if.launch_o;
  assign u_if.replica_i = (mode == 2'd0) ? u_if.launch_o :
                          (mode == 2'd1) ? r_dly :
                          (mode == 2'd2) ? (u_if.launch_o ^ inj) : 1'b0;

  always @(negedge clk) if (u_if.err_pulse_o) n_pulse <= n_pulse + 1;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    u_if.enable_i    = 1'b0;
    u_if.alarm_ack_i = 1'b0;
    inj   = 1'b0;
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!u_if.window_done_o && n < budget);
    last_wait = n;
    check_vec("window_seen", 32'(u_if.window_done_o), 32'd1);
  endtask

  task automatic inject();
    inj = 1'b1;
    tick();
    inj = 1'b0;
    check_vec("pulse_latency", 32'(u_if.err_pulse_o), 32'd1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    u_if.enable_i    = 1'b0;
    u_if.alarm_ack_i = 1'b0;
    ticks(2);
    check_vec("rst_launch", 32'(u_if.launch_o), 32'd0);
    check_vec("rst_pulse", 32'(u_if.err_pulse_o), 32'd0);
    check_vec("rst_count", 32'(u_if.err_count_o), 32'd0);
    check_vec("rst_done", 32'(u_if.window_done_o), 32'd0);
    check_vec("rst_req", 32'(u_if.alarm_req_o), 32'd0);
    check_vec("rst_ovr", 32'(u_if.alarm_ovr_o), 32'd0);
`ifdef REPLICA_MON_STUCK_EN
    check_vec("rst_stuck", 32'(u_if.stuck_o), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Ideal chain: two clean windows.
    mode = 2'd0;
    u_if.enable_i = 1'b1;
    p0 = n_pulse;
    wait_done(400);
    check_vec("ideal_count", 32'(u_if.err_count_o), 32'd0);
    check_vec("ideal_req", 32'(u_if.alarm_req_o), 32'd0);
    l0 = u_if.launch_o;
    tick();
    check_vec("launch_toggle", 32'(u_if.launch_o ^ l0), 32'd1);
    wait_done(400);
    check_vec("ideal_pulses", 32'(n_pulse - p0), 32'd0);
    check_vec("ideal_req2", 32'(u_if.alarm_req_o), 32'd0);

    // Slow chain: every check fails.
    do_reset();
    mode = 2'd1;
    u_if.enable_i = 1'b1;
    p0 = n_pulse;
    wait_done(400);
    check_vec("slow_count", 32'(u_if.err_count_o), 32'd256);
    check_vec("slow_req_with_done", 32'(u_if.alarm_req_o), 32'd1);
    check_vec("slow_ovr", 32'(u_if.alarm_ovr_o), 32'd0);
    check_vec("slow_pulses", 32'(n_pulse - p0), 32'd256);
    ticks(255);
    u_if.alarm_ack_i = 1'b1;
    tick();
    u_if.alarm_ack_i = 1'b0;
    check_vec("window_period", 32'(u_if.window_done_o), 32'd1);
    check_vec("ack_hit_req", 32'(u_if.alarm_req_o), 32'd1);
    check_vec("ack_hit_ovr", 32'(u_if.alarm_ovr_o), 32'd0);
    tick();
    u_if.alarm_ack_i = 1'b1;
    tick();
    u_if.alarm_ack_i = 1'b0;
    check_vec("ack_clear", 32'(u_if.alarm_req_o), 32'd0);
    wait_done(400);
    check_vec("rearm_req", 32'(u_if.alarm_req_o), 32'd1);
    check_vec("rearm_ovr", 32'(u_if.alarm_ovr_o), 32'd0);
    wait_done(400);
    check_vec("ovr_req", 32'(u_if.alarm_req_o), 32'd1);
    check_vec("ovr_set", 32'(u_if.alarm_ovr_o), 32'd1);
    u_if.alarm_ack_i = 1'b1;
    tick();
    u_if.alarm_ack_i = 1'b0;
    check_vec("ovr_ack_req", 32'(u_if.alarm_req_o), 32'd0);
    check_vec("ovr_sticky", 32'(u_if.alarm_ovr_o), 32'd1);
    wait_done(400);
    check_vec("req_before_rst", 32'(u_if.alarm_req_o), 32'd1);
    ticks(50);
    rst_n = 1'b0;
    #1;
    check_vec("async_launch", 32'(u_if.launch_o), 32'd0);
    check_vec("async_pulse", 32'(u_if.err_pulse_o), 32'd0);
    check_vec("async_count", 32'(u_if.err_count_o), 32'd0);
    check_vec("async_req", 32'(u_if.alarm_req_o), 32'd0);
    check_vec("async_ovr", 32'(u_if.alarm_ovr_o), 32'd0);

    // Threshold boundary: 3 errors then 4 errors.
    do_reset();
    mode = 2'd2;
    u_if.enable_i = 1'b1;
    ticks(5);
    p0 = n_pulse;
    for (int i = 0; i < 3; i++) inject();
    wait_done(400);
    check_vec("thr3_count", 32'(u_if.err_count_o), 32'd3);
    check_vec("thr3_req", 32'(u_if.alarm_req_o), 32'd0);
    check_vec("thr3_pulses", 32'(n_pulse - p0), 32'd3);
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) inject();
    wait_done(400);
    check_vec("win_period_inj", 32'(last_wait), 32'd248);
    check_vec("thr4_count", 32'(u_if.err_count_o), 32'd4);
    check_vec("thr4_req", 32'(u_if.alarm_req_o), 32'd1);
    check_vec("thr4_pulses", 32'(n_pulse - p0), 32'd4);

    // Disable mid-window discards the partial count.
    do_reset();
    mode = 2'd2;
    u_if.enable_i = 1'b1;
    ticks(5);
    for (int i = 0; i < 10; i++) inject();
    ticks(70);
    u_if.enable_i = 1'b0;
    ticks(2);
    l0 = u_if.launch_o;
    ticks(4);
    check_vec("idle_launch_hold", 32'(u_if.launch_o), 32'(l0));
    check_vec("idle_count_kept", 32'(u_if.err_count_o), 32'd0);
    check_vec("idle_req", 32'(u_if.alarm_req_o), 32'd0);
    u_if.enable_i = 1'b1;
    ticks(5);
    for (int i = 0; i < 2; i++) inject();
    wait_done(400);
    check_vec("reenable_count", 32'(u_if.err_count_o), 32'd2);
    check_vec("reenable_req", 32'(u_if.alarm_req_o), 32'd0);

`ifdef REPLICA_MON_STUCK_EN
    do_reset();
    check_vec("stuck_clear", 32'(u_if.stuck_o), 32'd0);
    mode = 2'd3;
    u_if.enable_i = 1'b1;
    ticks(12);
    check_vec("stuck_set", 32'(u_if.stuck_o), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
